// File: rtl/mem_access_unit_if.sv
// Memory-side bus of mem_access_unit: request/write/address/data out, ack/read data back.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding memory access sequencer (IDLE -> ACCESS -> COMPLETE).
// Defining MEM_TIMEOUT_EN adds an 8-bit ACCESS-cycle counter that aborts after TIMEOUT cycles.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic              is_instr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ir_load,
  output logic              mdr_load,
  output logic [DATA_W-1:0] rdata_out,
  mem_access_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, COMPLETE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              instr_q, instr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
`endif

  logic start_any, start_bad;
  assign start_any = start_rd | start_wr;
  assign start_bad = (start_rd & start_wr) | (addr[1:0] != 2'b00);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must be in 1..255");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      instr_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      instr_q <= instr_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Rejected requests still pass through one ACCESS cycle (with mem_req held low)
  // so that every completion, good or bad, lands no earlier than cycle 2.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    instr_d = instr_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (start_any) begin
          err_d   = start_bad;
          state_d = ACCESS;
          if (!start_bad) begin
            addr_d  = addr;
            wdata_d = wdata;
            instr_d = is_instr;
            we_d    = start_wr;
          end
        end
      end
      ACCESS: begin
        if (err_q) begin
          state_d = COMPLETE;
        end else if (mem.mem_ack) begin
          if (!we_q) rdata_d = mem.mem_rdata;
          state_d = COMPLETE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = COMPLETE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == COMPLETE);
  assign err           = done & err_q;
  assign ir_load       = done & ~err_q & ~we_q & instr_q;
  assign mdr_load      = done & ~err_q & ~we_q & ~instr_q;
  assign rdata_out     = rdata_q;
  assign mem.mem_req   = (state_q == ACCESS) & ~err_q;
  assign mem.mem_we    = (state_q == ACCESS) & ~err_q & we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level expectation model.
module tb_mem_access_unit;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_rd = 1'b0, start_wr = 1'b0, is_instr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          busy, done, err, ir_load, mdr_load;
  logic [DW-1:0] rdata_out;

  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start_rd(start_rd), .start_wr(start_wr),
    .is_instr(is_instr), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .ir_load(ir_load), .mdr_load(mdr_load), .rdata_out(rdata_out),
    .mem(bus)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] model_rdata = '0;

  // One complete transaction: start in cycle 0, ack offered in cycle ack_at.
  task automatic do_txn(input string name, input bit rd, input bit wr, input bit instr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, input int ack_at,
                        input logic [DW-1:0] rd_data, input bit spur);
    bit         bad, e;
    int         k, dcyc;
    logic [6:0] exp_v, obs_v;
    bad = (rd && wr) || (a[1:0] != 2'b00);
    if (bad) begin
      e = 1'b1; k = 0; dcyc = 2;
    end else if (TO_EN && ack_at > TO) begin
      e = 1'b1; k = TO; dcyc = TO + 1;
    end else begin
      e = 1'b0; k = ack_at; dcyc = ack_at + 1;
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, bus.mem_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s idle_before got=%b want=000", name, {busy, done, bus.mem_req});
    end
    start_rd = rd; start_wr = wr; is_instr = instr; addr = a; wdata = wd;
    bus.mem_ack = spur; bus.mem_rdata = DW'($urandom);
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      exp_v = {1'b1, 1'(c == dcyc), 1'(c == dcyc && e),
               1'(c == dcyc && !e && rd && instr), 1'(c == dcyc && !e && rd && !instr),
               1'(!bad && c <= k), 1'(!bad && c <= k && wr)};
      obs_v = {busy, done, err, ir_load, mdr_load, bus.mem_req, bus.mem_we};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s ctl c=%0d {busy,done,err,ir,mdr,req,we} got=%b want=%b",
                 name, c, obs_v, exp_v);
      end
      if (!bad && c <= k) begin
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata} !== {a, wd}) begin
          n_bad++;
          $display("FAIL %s bus c=%0d got=%h/%h want=%h/%h", name, c,
                   bus.mem_addr, bus.mem_wdata, a, wd);
        end
      end
      if (c == dcyc) begin
        if (!e && rd) model_rdata = rd_data;
        n_cmp++;
        if (rdata_out !== model_rdata) begin
          n_bad++;
          $display("FAIL %s rdata_done got=%h want=%h", name, rdata_out, model_rdata);
        end
      end
      start_rd = spur; start_wr = 1'b0;
      bus.mem_ack   = (c == ack_at) || (spur && c == dcyc);
      bus.mem_rdata = (c == ack_at) ? rd_data : DW'($urandom);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, err, ir_load, mdr_load, bus.mem_req, bus.mem_we} !== 7'b0 ||
        rdata_out !== model_rdata) begin
      n_bad++;
      $display("FAIL %s idle_after ctl=%b rdata got=%h want=%h", name,
               {busy, done, err, ir_load, mdr_load, bus.mem_req, bus.mem_we},
               rdata_out, model_rdata);
    end
    start_rd = 1'b0; start_wr = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({busy, done, err, ir_load, mdr_load, bus.mem_req, bus.mem_we} !== 7'b0 ||
          bus.mem_addr !== '0 || bus.mem_wdata !== '0 || rdata_out !== '0) begin
        n_bad++;
        $display("FAIL reset_state i=%0d ctl=%b addr=%h wdata=%h rdata=%h want all 0", i,
                 {busy, done, err, ir_load, mdr_load, bus.mem_req, bus.mem_we},
                 bus.mem_addr, bus.mem_wdata, rdata_out);
      end
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed();
    do_txn("ir_read",   1, 0, 1, 32'h0040_0000, 32'h0,         3, 32'h8C22_0004, 0);
    do_txn("write",     0, 1, 0, 32'h1001_0008, 32'hDEAD_BEEF, 1, 32'h1234_5678, 0);
    do_txn("misalign",  1, 0, 0, 32'h1001_0002, 32'h0,         1, 32'hAAAA_5555, 0);
    do_txn("rd_and_wr", 1, 1, 0, 32'h1001_0010, 32'h5,         1, 32'h7777_7777, 0);
    do_txn("busy_ign",  1, 0, 0, 32'h1001_0020, 32'h0,         2, 32'h0BAD_F00D, 1);
    do_txn("long_wait", 1, 0, 1, 32'h0040_0004, 32'h0,        12, 32'h2402_000A, 0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_txn("timeout",   1, 0, 0, 32'h1001_0040, 32'h0, 100, 32'hFFFF_0000, 0);
    do_txn("ack_final", 1, 0, 0, 32'h1001_0044, 32'h0,   4, 32'h0F0F_0F0F, 0);
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    start_rd = 1'b1; is_instr = 1'b0; addr = 32'h0000_2000;
    @(negedge clk);
    start_rd = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid req_before got=%b want=1", bus.mem_req);
    end
    reset = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_CAFE;
    #1;
    model_rdata = '0;
    n_cmp++;
    if ({busy, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL rst_mid req_drop busy=%b req=%b addr=%h want 0/0/0", busy, bus.mem_req,
               bus.mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done, ir_load, mdr_load, busy} !== 4'b0) begin
        n_bad++;
        $display("FAIL rst_mid no_done i=%0d got=%b want=0000", i, {done, ir_load, mdr_load, busy});
      end
    end
    reset = 1'b1; bus.mem_ack = 1'b0;
    do_txn("after_rst", 1, 0, 0, 32'h0000_2004, 32'h0, 2, 32'h1357_9BDF, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit            rd, wr, ins, sp;
      logic [AW-1:0] a;
      int            op;
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op >= 5);
      wr = (op <= 4);
      ins = 1'($urandom);
      sp  = 1'($urandom);
      a = AW'($urandom) & ~AW'(3);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_txn("random", rd, wr, ins, a, DW'($urandom), $urandom_range(1, 6), DW'($urandom), sp);
    end
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_directed();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
